// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore control sequencer for the 32-bit MIPS multi-cycle datapath. The
//   state register drives every datapath mux select and write enable for
//   one step per cycle: fetch, decode, memory access, ALU work and PC update.
//
// Optional feature (macro MC_BNE_EN):
//   defined   -> opcode 000101 (bne) is decoded and branches when zero = 0
//   undefined -> opcode 000101 is treated as an illegal opcode
//
// Ports:
//   clk          in   system clock, rising-edge state updates
//   reset_n      in   asynchronous active-low reset
//   opcode[5:0]  in   instr[31:26] from the instruction register
//   funct[5:0]   in   instr[5:0] from the instruction register
//   zero         in   ALU zero flag
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a
//                out  single-bit datapath selects / write enables
//   alu_src_b[1:0], pc_src[1:0]   out  datapath mux selects
//   pc_en        out  PC load enable (pc_write | branch & taken)
//   alu_control[2:0] out ALU function
//   illegal_op   out  high in DECODE when the opcode is not recognised
//   state[3:0]   out  current state code, for debug
module multicycle_control_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state_q, state_d;

    // Raw Moore outputs before reset gating
    logic       ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;
    logic       pc_write, branch, branch_taken, state_ok;
    logic [1:0] alu_op;

    // ALU function decode from ALUOp and the R-type funct field
    function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] fn);
        logic [2:0] ctl;
        ctl = 3'b010;
        if (op == 2'b01) begin
            ctl = 3'b110;
        end else if (op == 2'b10) begin
            case (fn)
                6'b100000: ctl = 3'b010;
                6'b100010: ctl = 3'b110;
                6'b100100: ctl = 3'b000;
                6'b100101: ctl = 3'b001;
                6'b101010: ctl = 3'b111;
                default:   ctl = 3'b010;
            endcase
        end
        return ctl;
    endfunction

`ifdef MC_BNE_EN
    // Remember which branch flavour was decoded so BRANCH need not re-read opcode
    logic is_bne_q, is_bne_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            is_bne_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_bne_q <= is_bne_d;
        end
    end

    always_comb begin
        is_bne_d = is_bne_q;
        if (state_q == S_DECODE) begin
            is_bne_d = (opcode == OP_BNE);
        end
    end

    assign branch_taken = is_bne_q ? ~zero : zero;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign branch_taken = zero;
`endif

    always_comb begin
        state_d       = S_FETCH;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        alu_op        = 2'b00;
        illegal_raw   = 1'b0;
        state_ok      = 1'b1;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                // Unused codes 12-15: everything low, recover through FETCH
                state_ok = 1'b0;
            end
        endcase
    end

    // Write enables are gated by reset_n so an asserted reset kills them at once
    assign ir_write    = ir_write_raw & reset_n;
    assign mem_write   = mem_write_raw & reset_n;
    assign reg_write   = reg_write_raw & reset_n;
    assign illegal_op  = illegal_raw & reset_n;
    assign pc_en       = (pc_write | (branch & branch_taken)) & reset_n;
    assign alu_control = state_ok ? alu_decode(alu_op, funct) : 3'b000;
    assign state       = state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Control sequencer for the 32-bit MIPS multi-cycle datapath. Decodes the instruction register's opcode/funct fields and walks a Moore state machine that drives every datapath mux select and write enable: instruction fetch, register/memory access, ALU operation and PC update, one step per cycle. Sits inside the multi-cycle top level beside the datapath. Replaces ad-hoc control logic with one self-contained, verifiable block.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- iord  out  1  memory address select (0 = PC, 1 = ALUOut)
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register load enable
- reg_dst  out  1  write-register select (0 = rt, 1 = rd)
- mem_to_reg  out  1  write-data select (0 = ALUOut, 1 = memory data)
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select (0 = PC, 1 = A register)
- alu_src_b  out  2  ALU B select (00 B reg, 01 const 4, 10 sign-ext imm, 11 imm<<2)
- pc_src  out  2  next-PC select (00 ALU result, 01 ALUOut, 10 jump target)
- pc_en  out  1  PC load enable = pc_write | (branch & branch_taken)
- alu_control  out  3  ALU function (010 add, 110 sub, 000 and, 001 or, 111 slt)
- illegal_op  out  1  one-cycle pulse on unrecognised opcode
- state  out  4  current state, debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12–15 → FETCH next cycle, all outputs 0.
- Transitions: FETCH→DECODE. DECODE by opcode: 100011/101011→MEMADR; 000000→EXECUTE; 000100→BRANCH; 001000→ADDIEXEC; 000010→JUMP; other→FETCH with illegal_op=1 that cycle. MEMADR→MEMRD (lw) or MEMWR (sw). MEMRD→MEMWB. MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP→FETCH. EXECUTE→ALUWB. ADDIEXEC→ADDIWB.
- Moore outputs (unlisted = 0):
  - FETCH: alu_src_b=01, ir_write=1, pc_write=1
  - DECODE: alu_src_b=11
  - MEMADR/ADDIEXEC: alu_src_a=1, alu_src_b=10
  - MEMRD: iord=1
  - MEMWB: mem_to_reg=1, reg_write=1
  - MEMWR: iord=1, mem_write=1
  - EXECUTE: alu_src_a=1, ALUOp=10
  - ALUWB: reg_dst=1, reg_write=1
  - BRANCH: alu_src_a=1, ALUOp=01, pc_src=01, branch=1
  - ADDIWB: reg_write=1
  - JUMP: pc_src=10, pc_write=1
- ALU decode: ALUOp 00→010; 01→110; 10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→010.
- branch_taken = zero (beq).

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Outputs combinational from state register plus zero/funct; no extra latency.
- reset_n low: state=FETCH immediately (async); ir_write, pc_en, reg_write, mem_write, illegal_op forced 0; other outputs at FETCH values. First rising edge after release executes FETCH.
- Reset mid-instruction: abandoned, no partial write enables after assertion.
- opcode/funct sampled only in DECODE/MEMADR/EXECUTE; datapath holds IR stable (ir_write=0) outside FETCH.

## Configuration
- MC_BNE_EN defined: opcode 000101 (bne) → BRANCH; in BRANCH, branch_taken = ~zero for bne, zero for beq; bne 3 cycles.
- Undefined: 000101 is illegal (DECODE→FETCH, illegal_op pulse).

## Test plan
- Reset: reset_n=0 → state=0, ir_write/pc_en/reg_write/mem_write=0; release → state 0,1 on successive edges.
- lw (100011) → states 0,1,2,3,4,0; MEMWB reg_write=1, mem_to_reg=1; sw (101011) → 0,1,2,5,0 with mem_write=1 only in state 5.
- R-type funct 101010 → EXECUTE alu_control=111, ALUWB reg_dst=1; funct 100010 → 110.
- beq zero=1 → pc_en=1, pc_src=01 in BRANCH; zero=0 → pc_en=0; j → pc_en=1, pc_src=10.
- Opcode 111111 → DECODE→FETCH, illegal_op=1 exactly one cycle; with MC_BNE_EN, 000101 zero=0 → pc_en=1.
- reset_n pulsed low during MEMWR → mem_write drops asynchronously, state=0.
